// File: rtl/sieve_pkg.sv
// Shared definitions for the sieve: FSM state encoding and RAM flag meaning.
package sieve_pkg;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    MARK  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic FLAG_PRIME     = 1'b0;
  localparam logic FLAG_COMPOSITE = 1'b1;

  // 0 and 1 are not primes, so they start out marked composite.
  function automatic logic clear_flag(input logic below_two);
    return below_two ? FLAG_COMPOSITE : FLAG_PRIME;
  endfunction

endpackage

// File: rtl/sieve_blockram.sv
// Single-port RAM companion for the sieve, instantiated beside it at system level.
// Registered read returns the old contents on a same-address write.
module blockram #(
  parameter int DATA = 8,
  parameter int ADDR = 8
) (
  input  logic            clk,
  input  logic [ADDR-1:0] addr,
  input  logic            wr,
  input  logic [DATA-1:0] din,
  output logic [DATA-1:0] dout
);

  logic [DATA-1:0] mem [0:(1<<ADDR)-1];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/sieve.sv
// Sieve of Eratosthenes over 0..2^ADDR-1 driving an external RAM; primes reported on out_rdy.
// Optional macro SIEVE_PRIME_COUNT_EN adds the out_count prime counter output.
module sieve #(
  parameter int ADDR = 8,
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [ADDR-1:0] out_addr,
  output logic            out_wr,
  output logic [DATA-1:0] out_dout,
  input  logic [DATA-1:0] in_din,
  output logic            out_rdy,
`ifdef SIEVE_PRIME_COUNT_EN
  output logic [ADDR:0]   out_count,
`endif
  output logic            out_done
);
  import sieve_pkg::*;

  localparam logic [ADDR-1:0]   ADDR_MAX = '1;
  localparam logic [ADDR:0]     N_P      = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0]     P_LAST   = {1'b0, {ADDR{1'b1}}};
  localparam logic [2*ADDR-1:0] N_SQ     = (2*ADDR)'(N_P);

  state_t          state_r, state_n;
  logic [ADDR-1:0] cnt_r, cnt_n;
  logic [ADDR:0]   p_r, p_n;
  logic [ADDR:0]   m_r, m_n;

  logic [2*ADDR-1:0] sq_s;
  logic [ADDR:0]     mp_s;
  logic [ADDR-1:0]   addr_s;
  logic              wr_s;
  logic              flag_s;
  logic              rdy_s;
  logic              done_s;
  logic [DATA-1:0]   dout_s;
  logic              unused_din_s;

  assign sq_s = ((2*ADDR)'(p_r)) * ((2*ADDR)'(p_r));
  assign mp_s = m_r + p_r;
  assign unused_din_s = ^in_din[DATA-1:1];

  // State and sieve counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= CLEAR;
      cnt_r   <= '0;
      p_r     <= '0;
      m_r     <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      p_r     <= p_n;
      m_r     <= m_n;
    end
  end

  // Next-state and RAM bus decode.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    p_n     = p_r;
    m_n     = m_r;
    addr_s  = '0;
    wr_s    = 1'b0;
    flag_s  = FLAG_PRIME;
    rdy_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      CLEAR: begin
        addr_s = cnt_r;
        wr_s   = 1'b1;
        flag_s = clear_flag(cnt_r < ADDR'(2));
        if (cnt_r == ADDR_MAX) begin
          state_n = FETCH;
          cnt_n   = '0;
          p_n     = (ADDR+1)'(2);
        end else begin
          cnt_n = cnt_r + ADDR'(1);
        end
      end
      FETCH: begin
        addr_s  = p_r[ADDR-1:0];
        state_n = CHECK;
      end
      CHECK: begin
        addr_s = p_r[ADDR-1:0];
        if (in_din[0] == FLAG_PRIME) begin
          rdy_s = 1'b1;
          if (sq_s < N_SQ) begin
            state_n = MARK;
            m_n     = sq_s[ADDR:0];
          end else begin
            state_n = NEXT;
          end
        end else begin
          state_n = NEXT;
        end
      end
      MARK: begin
        addr_s = m_r[ADDR-1:0];
        wr_s   = 1'b1;
        flag_s = FLAG_COMPOSITE;
        if (mp_s >= N_P) begin
          state_n = NEXT;
        end else begin
          m_n = mp_s;
        end
      end
      NEXT: begin
        addr_s = p_r[ADDR-1:0];
        if (p_r == P_LAST) begin
          state_n = DONE;
        end else begin
          p_n     = p_r + (ADDR+1)'(1);
          state_n = FETCH;
        end
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        state_n = CLEAR;
      end
    endcase
  end

  // Outputs are forced low combinationally so they drop the instant reset asserts.
  always_comb begin
    dout_s    = '0;
    dout_s[0] = flag_s & rst;
  end

  assign out_addr = rst ? addr_s : '0;
  assign out_wr   = wr_s & rst;
  assign out_dout = dout_s;
  assign out_rdy  = rdy_s & rst;
  assign out_done = done_s & rst;

`ifdef SIEVE_PRIME_COUNT_EN
  logic [ADDR:0] count_r;

  // Running total of reported primes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (out_rdy) begin
      count_r <= count_r + (ADDR+1)'(1);
    end
  end

  assign out_count = count_r;
`endif

endmodule

// File: tb/tb_sieve.sv
// Self-checking bench for sieve + blockram: reference primes and mark writes come from
// trial division; includes random mid-run resets and a reset during the p=3 marking pass.
module tb_sieve;

  localparam int ADDR = 8;
  localparam int DATA = 8;
  localparam int N    = 1 << ADDR;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [ADDR-1:0] out_addr;
  logic            out_wr;
  logic [DATA-1:0] out_dout;
  logic [DATA-1:0] in_din;
  logic            out_rdy;
  logic            out_done;
`ifdef SIEVE_PRIME_COUNT_EN
  logic [ADDR:0]   out_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bit is_prime [0:N-1];
  int exp_primes[$];
  int exp_marks[$];

  always #5 clk = ~clk;

  sieve #(.ADDR(ADDR), .DATA(DATA)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .out_addr (out_addr),
    .out_wr   (out_wr),
    .out_dout (out_dout),
    .in_din   (in_din),
    .out_rdy  (out_rdy),
`ifdef SIEVE_PRIME_COUNT_EN
    .out_count(out_count),
`endif
    .out_done (out_done)
  );

  blockram #(.DATA(DATA), .ADDR(ADDR)) u_ram (
    .clk (clk),
    .addr(out_addr),
    .wr  (out_wr),
    .din (out_dout),
    .dout(in_din)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, 32'({out_addr, out_wr, out_dout, out_rdy, out_done}), 32'd0);
  endtask

  task automatic build_model();
    for (int i = 0; i < N; i++) begin
      bit pr;
      pr = (i >= 2);
      for (int d = 2; d * d <= i; d++) begin
        if (i % d == 0) pr = 1'b0;
      end
      is_prime[i] = pr;
      if (pr) exp_primes.push_back(i);
    end
    foreach (exp_primes[k]) begin
      int p;
      p = exp_primes[k];
      for (int m = p * p; m < N; m += p) exp_marks.push_back(m);
    end
  endtask

  // abort_cyc >= 0: reset at that cycle count; abort_k > 0: reset at the k-th write of p=3.
  task automatic run_sieve(input int abort_cyc, input int abort_k);
    int  cyc;
    int  pi;
    int  wi;
    int  last_prime;
    int  marks3;
    bit  aborted;
    logic [7:0] a8;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      #1;
      a8 = i[7:0];
      check_eq("clear", 32'({out_wr, out_rdy, out_done, out_addr, out_dout}),
               32'({1'b1, 1'b0, 1'b0, a8, 8'(i < 2 ? 1 : 0)}));
      @(negedge clk);
    end
    cyc = N; pi = 0; wi = 0; last_prime = -1; marks3 = 0; aborted = 1'b0;
    while (!out_done && cyc < 4096 && !aborted) begin
      #1;
      if (out_rdy) begin
        if (pi < exp_primes.size()) begin
          check_eq("prime", 32'(out_addr), 32'(exp_primes[pi]));
          if (last_prime >= 0 && int'(out_addr) <= last_prime)
            check_eq("prime_increasing", 32'(out_addr), 32'(last_prime + 1));
        end else begin
          check_eq("prime_count_overflow", 32'(pi + 1), 32'(exp_primes.size()));
        end
        last_prime = int'(out_addr);
        pi++;
      end
      if (out_wr) begin
        if (wi < exp_marks.size()) begin
          check_eq("mark", 32'({out_addr, out_dout}), 32'({8'(exp_marks[wi]), 8'd1}));
        end else begin
          check_eq("mark_count_overflow", 32'(wi + 1), 32'(exp_marks.size()));
        end
        wi++;
        if (last_prime == 3) marks3++;
        if (abort_k > 0 && marks3 == abort_k) aborted = 1'b1;
      end
      if (abort_cyc >= 0 && cyc == abort_cyc) aborted = 1'b1;
      if (aborted) begin
        rst = 1'b0;
        #1;
        check_reset_outputs("abort_outputs");
        repeat (2 + $urandom_range(0, 3)) @(negedge clk);
        check_reset_outputs("abort_hold");
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!aborted) begin
      #1;
      check_eq("done_in_time", 32'(out_done), 32'd1);
      check_eq("n_primes", 32'(pi), 32'(exp_primes.size()));
      check_eq("n_marks", 32'(wi), 32'(exp_marks.size()));
`ifdef SIEVE_PRIME_COUNT_EN
      check_eq("count", 32'(out_count), 32'd54);
`endif
      for (int i = 0; i < N; i++) begin
        check_eq("ram_flag", 32'(u_ram.mem[i][0]), 32'(is_prime[i] ? 0 : 1));
      end
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        #1;
        check_eq("done_hold", 32'({out_done, out_wr, out_rdy}), 32'(3'b100));
      end
    end
  endtask

  initial begin
    build_model();
    check_eq("model_prime_total", 32'(exp_primes.size()), 32'd54);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_outputs");
    repeat (3 + $urandom_range(0, 4)) @(negedge clk);
    check_reset_outputs("reset_hold");
    run_sieve(N + int'($urandom_range(0, 900)), 0);
    run_sieve(-1, int'($urandom_range(1, 40)));
    run_sieve(-1, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sieve.md
SIEVE -- requirements
Module: sieve

Interface
REQ-001 SHALL have parameter ADDR, default 8: RAM address width; the sieve covers N = 2^ADDR integers 0..N-1.
REQ-002 SHALL have parameter DATA, default 8: RAM data width; only bit 0 carries a flag, upper bits are written as 0.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port out_addr, output, ADDR: RAM address.
REQ-006 SHALL have port out_wr, output, 1: RAM write enable.
REQ-007 SHALL have port out_dout, output, DATA: RAM write data.
REQ-008 SHALL have port in_din, input, DATA: RAM read data; a synchronous read, valid one cycle after out_addr is presented with out_wr=0.
REQ-009 SHALL have port out_rdy, output, 1: one-cycle pulse reporting a prime; out_addr equals that prime in the same cycle.
REQ-010 SHALL have port out_done, output, 1: sieve complete; sticky.

Function
REQ-011 SHALL treat RAM flag 0 as "candidate/prime" and flag 1 as "composite".
REQ-012 SHALL enter state CLEAR after reset and write out_addr = 0..N-1 on consecutive cycles with out_wr=1, taking N cycles.
REQ-013 In CLEAR, out_dout SHALL be 1 for addresses 0 and 1, and 0 for all other addresses.
REQ-014 SHALL then enter FETCH with p=2, driving out_addr=p and out_wr=0.
REQ-015 SHALL then enter CHECK on the next cycle and sample in_din.
REQ-016 In CHECK, if in_din bit0 is 0, the block SHALL assert out_rdy for exactly that cycle with out_addr held at p.
REQ-017 In CHECK, for a prime p with p*p < N, the block SHALL go to MARK with m = p*p; otherwise it SHALL go to NEXT.
REQ-018 In MARK, the block SHALL drive out_addr=m, out_wr=1 and out_dout=1, one write per cycle.
REQ-019 In MARK, the block SHALL step m by p each cycle and go to NEXT after the write at which m+p >= N.
REQ-020 In NEXT, if p == N-1 the block SHALL go to DONE; otherwise it SHALL increment p and go to FETCH.
REQ-021 In DONE, the block SHALL hold out_done=1, out_wr=0 and out_rdy=0 indefinitely until reset.
REQ-022 SHALL hold p and m at ADDR+1 bits and compute p*p at 2*ADDR bits so that no wrap-around is possible.
REQ-023 SHALL never drive out_wr=1 outside CLEAR and MARK.
REQ-024 For ADDR=8, the block SHALL assert out_done within 4096 cycles of reset release.

Reset
REQ-025 While rst=0, all outputs SHALL be 0 immediately.
REQ-026 While rst=0, the state SHALL be CLEAR with its address counter, p and m at 0.
REQ-027 Reset asserted mid-operation SHALL abort the current operation; the block SHALL restart with a full CLEAR on release.
REQ-028 The block SHALL not rely on prior RAM contents.

Configuration
REQ-029 With macro SIEVE_PRIME_COUNT_EN defined, the block SHALL add output out_count, ADDR+1 bits wide, reset to 0 and incremented on each out_rdy pulse.
REQ-030 Without SIEVE_PRIME_COUNT_EN, out_count and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package SHALL hold the state enum (CLEAR, FETCH, CHECK, MARK, NEXT, DONE) and the flag constants FLAG_PRIME=0 and FLAG_COMPOSITE=1.
REQ-032 blockram SHALL be the one companion module, with parameters DATA and ADDR and ports clk, addr, wr, din, dout.
REQ-033 blockram SHALL write on the rising edge when wr=1 and SHALL provide a registered read, dout <= mem[addr], returning the old data.
REQ-034 blockram SHALL be instantiated beside sieve at system level, not inside it.

Verification
REQ-035 Scenario: release reset -> first 256 cycles have out_wr=1, out_addr 0..255, and out_dout 1,1,0,0,...,0.
REQ-036 Scenario: full run with ADDR=8 -> out_rdy pulses with out_addr 2,3,5,7,11,...,251, exactly 54 pulses, strictly increasing.
REQ-037 Scenario: marking -> p=2 writes addresses 4,6,...,254; p=17 (289 >= 256) produces no MARK writes.
REQ-038 Scenario: after out_done -> RAM[i] bit0 == 0 exactly for prime i; out_done stays 1 and out_wr stays 0 for the following 20 cycles.
REQ-039 Scenario: rst=0 pulsed during MARK for p=3 -> outputs go to 0 at once; after release, CLEAR repeats and the same 54-prime sequence follows.
REQ-040 Scenario: build with SIEVE_PRIME_COUNT_EN -> out_count == 54 when out_done rises.
